// File: rtl/player_health_manager.sv
// Player lives, post-hit invulnerability blink and game-over/restart control.
// Collisions are latched within a frame and acted on at the frame_end pulse.
module player_health_manager #(
  parameter int MAX_LIVES      = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int FLASH_FRAMES   = 8,
  parameter int RESTART_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end,
  input  logic       player_hit,
  input  logic       sheep_eaten,
  input  logic       restart,
  output logic [1:0] lives,
  output logic       player_visible,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       dragon_grow
);

  localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam int RO_W    = $clog2(RESTART_FRAMES + 1);

  typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic               visible_q, visible_d;
  logic               game_over_q, game_over_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               dragon_grow_q, dragon_grow_d;
  logic               hit_l_q, hit_l_d;
  logic               sheep_l_q, sheep_l_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [RO_W-1:0]    ro_cnt_q, ro_cnt_d;
  logic               eff_hit, eff_sheep;

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    visible_d     = visible_q;
    game_over_d   = game_over_q;
    hit_pulse_d   = 1'b0;
    dragon_grow_d = 1'b0;
    inv_cnt_d     = inv_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    ro_cnt_d      = ro_cnt_q;
    // A collision on the frame_end cycle itself still belongs to this frame.
    eff_hit       = hit_l_q | player_hit;
    eff_sheep     = sheep_l_q | sheep_eaten;
    hit_l_d       = eff_hit;
    sheep_l_d     = eff_sheep;

    if (frame_end) begin
      hit_l_d       = 1'b0;
      sheep_l_d     = 1'b0;
      dragon_grow_d = eff_sheep && (state_q != GAME_OVER);

      case (state_q)
        PLAY: begin
          if (eff_hit) begin
            hit_pulse_d = 1'b1;
            visible_d   = 1'b0;
            if (lives_q <= 2'd1) begin
              state_d     = GAME_OVER;
              lives_d     = 2'd0;
              game_over_d = 1'b1;
              ro_cnt_d    = '0;
            end else begin
              state_d     = INVULN;
              lives_d     = lives_q - 2'd1;
              inv_cnt_d   = INV_W'(INVULN_FRAMES - 1);
              flash_cnt_d = '0;
            end
          end
        end

        INVULN: begin
          if (inv_cnt_q == '0) begin
            state_d     = PLAY;
            visible_d   = 1'b1;
            flash_cnt_d = '0;
          end else begin
            inv_cnt_d = inv_cnt_q - 1'b1;
            if (flash_cnt_q == FLASH_W'(FLASH_FRAMES - 1)) begin
              flash_cnt_d = '0;
              visible_d   = ~visible_q;
            end else begin
              flash_cnt_d = flash_cnt_q + 1'b1;
            end
          end
        end

        GAME_OVER: begin
          // Restart is only sampled once the lockout counter has saturated.
          if (ro_cnt_q == RO_W'(RESTART_FRAMES)) begin
            if (restart) begin
              state_d     = PLAY;
              lives_d     = 2'(MAX_LIVES);
              game_over_d = 1'b0;
              visible_d   = 1'b1;
            end
          end else begin
            ro_cnt_d = ro_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLAY;
      lives_q       <= 2'(MAX_LIVES);
      visible_q     <= 1'b1;
      game_over_q   <= 1'b0;
      hit_pulse_q   <= 1'b0;
      dragon_grow_q <= 1'b0;
      hit_l_q       <= 1'b0;
      sheep_l_q     <= 1'b0;
      inv_cnt_q     <= '0;
      flash_cnt_q   <= '0;
      ro_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      visible_q     <= visible_d;
      game_over_q   <= game_over_d;
      hit_pulse_q   <= hit_pulse_d;
      dragon_grow_q <= dragon_grow_d;
      hit_l_q       <= hit_l_d;
      sheep_l_q     <= sheep_l_d;
      inv_cnt_q     <= inv_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      ro_cnt_q      <= ro_cnt_d;
    end
  end

  assign lives          = lives_q;
  assign player_visible = visible_q;
  assign game_over      = game_over_q;
  assign hit_pulse      = hit_pulse_q;
  assign dragon_grow    = dragon_grow_q;

endmodule

// File: tb/tb_player_health_manager.sv
// Directed test of player_health_manager: hits, invulnerability blink,
// game-over lockout/restart, sheep growth pulses and asynchronous reset.
module tb_player_health_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_end;
  logic       player_hit;
  logic       sheep_eaten;
  logic       restart;
  logic [1:0] lives;
  logic       player_visible;
  logic       game_over;
  logic       hit_pulse;
  logic       dragon_grow;

  int total  = 0;
  int passed = 0;

  player_health_manager dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_end      (frame_end),
    .player_hit     (player_hit),
    .sheep_eaten    (sheep_eaten),
    .restart        (restart),
    .lives          (lives),
    .player_visible (player_visible),
    .game_over      (game_over),
    .hit_pulse      (hit_pulse),
    .dragon_grow    (dragon_grow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Idle cycles, then one frame_end cycle carrying the given collision/restart levels.
  task automatic do_frame(input logic hit, input logic sheep, input logic rs);
    repeat (3) tick();
    player_hit  = hit;
    sheep_eaten = sheep;
    restart     = rs;
    frame_end   = 1'b1;
    tick();
    player_hit  = 1'b0;
    sheep_eaten = 1'b0;
    restart     = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; frame_end = 1'b0; player_hit = 1'b0; sheep_eaten = 1'b0; restart = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1. reset values, then a long stretch without frame_end
    chk("rst_lives", lives, 3);
    chk("rst_visible", player_visible, 1);
    chk("rst_game_over", game_over, 0);
    chk("rst_hit_pulse", hit_pulse, 0);
    chk("rst_grow", dragon_grow, 0);
    repeat (1000) tick();
    chk("idle_lives", lives, 3);
    chk("idle_visible", player_visible, 1);

    // 2. mid-frame hit is latched and applied on frame_end (frame 0)
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    repeat (2) tick();
    chk("latched_no_fe", lives, 3);
    do_frame(1'b0, 1'b0, 1'b0);
    chk("hit1_lives", lives, 2);
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_visible", player_visible, 0);
    tick();
    chk("hit1_pulse_end", hit_pulse, 0);
    frames(7);
    chk("blink_f7", player_visible, 0);
    frames(1);
    chk("blink_f8", player_visible, 1);
    frames(1);

    // 3. hit during invulnerability (frame 10) ignored; sheep still grows
    do_frame(1'b1, 1'b1, 1'b0);
    chk("inv_hit_lives", lives, 2);
    chk("inv_hit_pulse", hit_pulse, 0);
    chk("inv_sheep_grow", dragon_grow, 1);
    tick();
    chk("inv_grow_end", dragon_grow, 0);
    frames(38);
    chk("blink_f48", player_visible, 0);
    frames(11);
    chk("blink_f59", player_visible, 1);
    chk("f59_lives", lives, 2);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("f60_hit_ignored", lives, 2);
    chk("f60_visible", player_visible, 1);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("f61_lives", lives, 1);
    chk("f61_pulse", hit_pulse, 1);
    chk("f61_visible", player_visible, 0);

    // 4. last life lost, restart lockout
    frames(60);
    chk("inv2_done_vis", player_visible, 1);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("go_lives", lives, 0);
    chk("go_flag", game_over, 1);
    chk("go_pulse", hit_pulse, 1);
    chk("go_visible", player_visible, 0);
    do_frame(1'b1, 1'b0, 1'b0);
    chk("go_hit_pulse", hit_pulse, 0);
    chk("go_hit_lives", lives, 0);
    // sheep mid-frame in GAME_OVER must not grow the dragon
    sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0;
    do_frame(1'b0, 1'b1, 1'b0);
    chk("go_no_grow", dragon_grow, 0);
    frames(47);
    do_frame(1'b0, 1'b0, 1'b1);
    chk("restart_f50", game_over, 1);
    frames(69);
    do_frame(1'b0, 1'b0, 1'b1);
    chk("restart_f120", game_over, 1);
    do_frame(1'b0, 1'b0, 1'b1);
    chk("restart_ok_go", game_over, 0);
    chk("restart_lives", lives, 3);
    chk("restart_vis", player_visible, 1);

    // 5. hit and sheep on the same frame_end cycle in PLAY
    do_frame(1'b1, 1'b1, 1'b0);
    chk("both_grow", dragon_grow, 1);
    chk("both_pulse", hit_pulse, 1);
    chk("both_lives", lives, 2);
    tick();
    chk("both_grow_end", dragon_grow, 0);
    chk("both_pulse_end", hit_pulse, 0);

    // 6. asynchronous reset during invulnerability with a pending hit latch
    frames(3);
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lives", lives, 3);
    chk("arst_visible", player_visible, 1);
    chk("arst_game_over", game_over, 0);
    tick();
    rst_n = 1'b1;
    do_frame(1'b0, 1'b0, 1'b0);
    chk("arst_latch_lives", lives, 3);
    chk("arst_latch_pulse", hit_pulse, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
